// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch front end.
package ifetch_pkg;

  localparam int unsigned IFETCH_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH,
    DROP,
    HALT
  } ifetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } ifetch_entry_t;

  // True when an address is not word-aligned.
  function automatic logic ifetch_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding fetched entries; flush beats push/pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = ifetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output entry_t                   head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the slot.
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr + 1'b1) & PTR_MASK;
      if (do_pop)  rd_ptr <= (rd_ptr + 1'b1) & PTR_MASK;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch: issues word fetches, buffers {instr, pc, err} and
// hands them to decode; redirects flush the buffer and drop stale responses.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  input  logic        im_err,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ifetch_state_e state_q;
  logic          run_q;
  logic          pending_q;
  logic          inj_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_addr_q;
  logic [31:0]   inj_pc_q;

  logic          xfer;
  logic          room;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  ifetch_entry_t push_entry;
  ifetch_entry_t head;

  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, pending_q};
  assign room      = !fifo_full && (occupancy < (CW+1)'(DEPTH));

  // An outstanding request is held until acked regardless of state or
  // redirect; a new one is only started from FETCH with buffer room.
  assign im_req  = run_q && (pending_q || (state_q == FETCH && !redirect && room));
  assign im_addr = pending_q ? req_addr_q : fetch_pc_q;
  assign xfer    = im_req && im_ack;

  // The misaligned-redirect error entry is injected the cycle after the
  // redirect, since the same-cycle flush would otherwise swallow it.
  always_comb begin
    push_entry = '{instr: im_rdata, pc: im_addr, err: im_err};
    fifo_push  = xfer && (state_q == FETCH) && !redirect;
    if (inj_q) begin
      push_entry = '{instr: 32'h0, pc: inj_pc_q, err: 1'b1};
      fifo_push  = 1'b1;
    end
  end

  assign fifo_pop  = out_valid && out_ready && !redirect;
  assign out_valid = !fifo_empty;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_err   = out_valid ? head.err   : 1'b0;

  ifetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (ifetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

  // Fetch control FSM, request tracking and redirect handling.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FETCH;
      run_q      <= 1'b0;
      pending_q  <= 1'b0;
      inj_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      inj_pc_q   <= '0;
    end else begin
      run_q <= 1'b1;
      inj_q <= 1'b0;

      if (xfer) begin
        pending_q <= 1'b0;
      end else if (im_req) begin
        pending_q  <= 1'b1;
        req_addr_q <= im_addr;
      end

      if (redirect) begin
        fetch_pc_q <= redirect_pc;
        if (ifetch_misaligned(redirect_pc)) begin
          state_q  <= HALT;
          inj_q    <= 1'b1;
          inj_pc_q <= redirect_pc;
        end else if (pending_q && !im_ack) begin
          state_q <= DROP;
        end else begin
          state_q <= FETCH;
        end
      end else begin
        unique case (state_q)
          FETCH: begin
            if (xfer) begin
              fetch_pc_q <= im_addr + 32'(IFETCH_WORD_BYTES);
              if (im_err) state_q <= HALT;
            end
          end
          DROP: begin
            if (xfer) state_q <= FETCH;
          end
          HALT: state_q <= HALT;
          default: state_q <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: cycle table for streaming/backpressure
// plus hand sequences for redirect, drop, error and wrap corner cases.
module tb_ifetch_prefetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        im_err;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_err;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model: ack after `lat` waiting cycles; lat=0 is combinational.
  int          lat = 0;
  int          wait_cnt = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0fe26013;
      32'h4:   return 32'h0002e213;
      32'h8:   return 32'h0fe26213;
      default: return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign im_ack   = im_req && (wait_cnt >= lat);
  assign im_rdata = mem_word(im_addr);
  assign im_err   = im_ack && err_en && (im_addr == err_addr);

  always @(posedge clk) begin
    if (im_req && !im_ack) wait_cnt <= wait_cnt + 1;
    else                   wait_cnt <= 0;
  end

  always #5 clk = ~clk;

  ifetch_prefetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .im_err      (im_err),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_err     (out_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        chk;
    logic        rst;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic chk, input logic r, input logic rdy,
                              input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc,
                              input logic [31:0] ins);
    vec_t t;
    t.chk = chk; t.rst = r; t.rdy = rdy; t.req = req; t.addr = addr;
    t.valid = v; t.pc = pc; t.instr = ins; t.err = 1'b0;
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        found;
    logic        got_first;
    logic        got_addr;
    logic        bad;
    logic        req_seen;
    logic [31:0] first_pc;
    logic [31:0] next_addr;
    logic        first_err;
    logic [31:0] first_instr;
    int          cnt;

    // Streaming from reset (rows 0-6), then backpressure from reset (7-20).
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,  0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,  0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 1, 32'h0,  0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 1, 32'h4,  1, 32'h0, 32'h0fe26013));
    vecs.push_back(mk(1, 1, 1, 1, 32'h8,  1, 32'h4, 32'h0002e213));
    vecs.push_back(mk(1, 1, 1, 1, 32'hC,  1, 32'h8, 32'h0fe26213));
    vecs.push_back(mk(1, 1, 1, 1, 32'h10, 1, 32'hC, mem_word(32'hC)));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,  0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,  0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,  0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 1, 32'h0,  0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 1, 32'h4,  1, 32'h0, 32'h0fe26013));
    vecs.push_back(mk(1, 1, 0, 1, 32'h8,  1, 32'h0, 32'h0fe26013));
    vecs.push_back(mk(1, 1, 0, 1, 32'hC,  1, 32'h0, 32'h0fe26013));
    vecs.push_back(mk(1, 1, 0, 0, 32'h10, 1, 32'h0, 32'h0fe26013));
    vecs.push_back(mk(1, 1, 0, 0, 32'h10, 1, 32'h0, 32'h0fe26013));
    vecs.push_back(mk(1, 1, 1, 0, 32'h10, 1, 32'h0, 32'h0fe26013));
    vecs.push_back(mk(1, 1, 1, 1, 32'h10, 1, 32'h4, 32'h0002e213));
    vecs.push_back(mk(1, 1, 1, 1, 32'h14, 1, 32'h8, 32'h0fe26213));
    vecs.push_back(mk(1, 1, 1, 1, 32'h18, 1, 32'hC, mem_word(32'hC)));
    vecs.push_back(mk(1, 1, 1, 1, 32'h1C, 1, 32'h10, mem_word(32'h10)));

    lat = 0;
    @(negedge clk);
    @(negedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      out_ready = vecs[i].rdy;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d_im_req", i), im_req, vecs[i].req);
        check($sformatf("v%0d_im_addr", i), im_addr, vecs[i].addr);
        check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].valid);
        if (vecs[i].valid || !vecs[i].rst) begin
          check($sformatf("v%0d_out_pc", i), out_pc, vecs[i].pc);
          check($sformatf("v%0d_out_instr", i), out_instr, vecs[i].instr);
          check($sformatf("v%0d_out_err", i), out_err, vecs[i].err);
        end
      end
    end

    // Redirect while a slow fetch of 0x8 is outstanding -> DROP.
    lat = 3;
    out_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #1;
      if (im_req && im_addr == 32'h8) found = 1'b1;
    end
    check("s3_req8_seen", found, 1'b1);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("s3_ack_low", im_ack, 1'b0);
    check("s3_req_held", im_req, 1'b1);
    check("s3_addr_held", im_addr, 32'h8);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("s3_state_drop", 32'(dut.state_q), 32'(DROP));
    check("s3_stale_addr", im_addr, 32'h8);
    got_first = 1'b0; got_addr = 1'b0; bad = 1'b0;
    first_pc = '0; next_addr = '0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid && out_pc == 32'h8) bad = 1'b1;
      if (out_valid && !got_first) begin got_first = 1'b1; first_pc = out_pc; end
      if (im_req && im_addr != 32'h8 && !got_addr) begin got_addr = 1'b1; next_addr = im_addr; end
      @(negedge clk); #1;
    end
    check("s3_stale_delivered", bad, 1'b0);
    check("s3_next_addr", next_addr, 32'h100);
    check("s3_first_pc", first_pc, 32'h100);

    // Redirect coinciding with the ack of 0x4 and a decode pop.
    lat = 1;
    out_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #1;
      if (im_req && im_ack && im_addr == 32'h4) found = 1'b1;
    end
    check("s4_ack4_seen", found, 1'b1);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    out_ready = 1'b1;
    #1;
    check("s4_pop_offered", out_valid, 1'b1);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("s4_flushed", out_valid, 1'b0);
    check("s4_next_addr", im_addr, 32'h40);
    check("s4_next_req", im_req, 1'b1);
    got_first = 1'b0; bad = 1'b0; first_pc = '0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && (out_pc == 32'h0 || out_pc == 32'h4)) bad = 1'b1;
      if (out_valid && !got_first) begin got_first = 1'b1; first_pc = out_pc; end
      @(negedge clk); #1;
    end
    check("s4_stale_delivered", bad, 1'b0);
    check("s4_first_pc", first_pc, 32'h40);

    // Fetch error at 0xC halts fetching; redirect to 0 restarts.
    lat = 0;
    out_ready = 1'b1;
    err_en = 1'b1;
    err_addr = 32'hC;
    do_reset();
    found = 1'b0; bad = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (out_valid && out_pc != 32'hC && out_err) bad = 1'b1;
      if (out_valid && out_pc == 32'hC) found = 1'b1;
    end
    check("s5_errpc_seen", found, 1'b1);
    check("s5_early_err", bad, 1'b0);
    check("s5_out_err", out_err, 1'b1);
    check("s5_out_instr", out_instr, mem_word(32'hC));
    check("s5_req_halted", im_req, 1'b0);
    req_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (im_req) req_seen = 1'b1;
    end
    check("s5_req_after_halt", req_seen, 1'b0);
    check("s5_drained", out_valid, 1'b0);
    @(negedge clk);
    err_en = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0;
    #1;
    check("s5_req_in_redirect", im_req, 1'b0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("s5_restart_req", im_req, 1'b1);
    check("s5_restart_addr", im_addr, 32'h0);

    // Misaligned redirect yields a single error entry and no fetch.
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("s6_req_off", im_req, 1'b0);
    check("s6_flushed", out_valid, 1'b0);
    cnt = 0; req_seen = 1'b0;
    first_pc = '0; first_err = 1'b0; first_instr = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (im_req) req_seen = 1'b1;
      if (out_valid) begin
        if (cnt == 0) begin first_pc = out_pc; first_err = out_err; first_instr = out_instr; end
        cnt++;
      end
    end
    check("s6_entry_count", 32'(cnt), 32'd1);
    check("s6_entry_pc", first_pc, 32'h102);
    check("s6_entry_err", first_err, 1'b1);
    check("s6_entry_instr", first_instr, 32'h0);
    check("s6_no_req", req_seen, 1'b0);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("s6_resume_req", im_req, 1'b1);
    check("s6_resume_addr", im_addr, 32'h200);

    // Address wrap, then back-to-back redirects where the last one wins.
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("s7_top_addr", im_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("s7_wrap_addr", im_addr, 32'h0);
    check("s7_top_pc", out_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect_pc = 32'h400;
    #1;
    check("s7_req_in_b2b", im_req, 1'b0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("s7_b2b_addr", im_addr, 32'h400);
    check("s7_b2b_flushed", out_valid, 1'b0);
    @(negedge clk); #1;
    check("s7_b2b_valid", out_valid, 1'b1);
    check("s7_b2b_pc", out_pc, 32'h400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
